// File: rtl/sar_search_unit_if.sv
// Candidate/verdict handshake between the search initiator and a magnitude comparator.
// The master drives candidates; the slave (comparator) returns gt/eq/lt verdicts.
interface sar_search_unit_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] cand;
  logic             cand_valid;
  logic             resp_valid;
  logic             x_gt_y;
  logic             x_eq_y;
  logic             x_lt_y;

  modport master (
    output cand,
    output cand_valid,
    input  resp_valid,
    input  x_gt_y,
    input  x_eq_y,
    input  x_lt_y
  );

  modport slave (
    input  cand,
    input  cand_valid,
    output resp_valid,
    output x_gt_y,
    output x_eq_y,
    output x_lt_y
  );
endinterface

// File: rtl/sar_search_unit.sv
// Successive-approximation search initiator: binary-searches 0..2^WIDTH-1 against an
// external comparator's hidden target and reports match, probe count and status.
module sar_search_unit #(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned PW    = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  sar_search_unit_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [WIDTH-1:0]  result,
  output logic [PW-1:0]     probes,
  output logic              err
);

  localparam int unsigned   W1     = WIDTH + 1;
  localparam logic [W1-1:0] HI_MAX = W1'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [W1-1:0]    lo_q, lo_n;
  logic [W1-1:0]    hi_q, hi_n;
  logic [WIDTH-1:0] cand_q, cand_n;
  logic             cval_q, cval_n;
  logic [PW-1:0]    probes_q, probes_n;
  logic             found_q, found_n;
  logic             err_q, err_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;

  // The registered candidate is always the midpoint of the current lo/hi window.
  logic [W1-1:0]    mid;
  logic [W1-1:0]    lo_up;
  logic [W1-1:0]    hi_dn;
  logic [2:0]       verdict;

  assign mid     = {1'b0, cand_q};
  assign lo_up   = mid + W1'(1);
  assign hi_dn   = mid - W1'(1);
  assign verdict = {bus.x_gt_y, bus.x_eq_y, bus.x_lt_y};

  always_comb begin
    logic finish;
    logic exhausted;
    state_n   = state_q;
    lo_n      = lo_q;
    hi_n      = hi_q;
    cand_n    = cand_q;
    cval_n    = cval_q;
    probes_n  = probes_q;
    found_n   = found_q;
    err_n     = err_q;
    result_n  = result_q;
    finish    = 1'b0;
    exhausted = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n  = PROBE;
          lo_n     = '0;
          hi_n     = HI_MAX;
          cand_n   = WIDTH'(HI_MAX >> 1);
          cval_n   = 1'b1;
          probes_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
          result_n = '0;
        end
      end

      PROBE: begin
        if (bus.resp_valid) begin
          probes_n = probes_q + PW'(1);
          if (!$onehot(verdict)) begin
            err_n    = 1'b1;
            found_n  = 1'b0;
            result_n = cand_q;
            finish   = 1'b1;
          end else if (bus.x_eq_y) begin
            found_n  = 1'b1;
            result_n = cand_q;
            finish   = 1'b1;
          end else if (bus.x_gt_y) begin
            if (lo_up > hi_q) begin
              exhausted = 1'b1;
            end else begin
              lo_n   = lo_up;
              cand_n = WIDTH'((lo_up + hi_q) >> 1);
            end
          end else begin
            // mid==0 is checked before hi_dn is used so hi never wraps.
            if ((mid == '0) || (lo_q > hi_dn)) begin
              exhausted = 1'b1;
            end else begin
              hi_n   = hi_dn;
              cand_n = WIDTH'((lo_q + hi_dn) >> 1);
            end
          end

          if (exhausted) begin
            found_n  = 1'b0;
            result_n = cand_q;
            finish   = 1'b1;
          end

          if (finish) begin
            state_n = DONE;
            cval_n  = 1'b0;
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cval_n  = 1'b0;
      end
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      cand_q   <= '0;
      cval_q   <= 1'b0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      lo_q     <= lo_n;
      hi_q     <= hi_n;
      cand_q   <= cand_n;
      cval_q   <= cval_n;
      probes_q <= probes_n;
      found_q  <= found_n;
      err_q    <= err_n;
      result_q <= result_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  assign bus.cand       = cand_q;
  assign bus.cand_valid = cval_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign found          = found_q;
  assign result         = result_q;
  assign probes         = probes_q;
  assign err            = err_q;

endmodule

// File: tb/tb_sar_search_unit.sv
// Self-checking bench for sar_search_unit: a plain-integer binary-search model predicts
// the probe sequence and final status; randomized targets, stalls and malformed verdicts.
module tb_sar_search_unit;

  localparam int unsigned WIDTH = 4;
  localparam int          MAXV  = (1 << WIDTH) - 1;
  localparam int unsigned PW    = $clog2(WIDTH + 2);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [WIDTH-1:0] result;
  logic [PW-1:0]    probes;

  int checks   = 0;
  int failures = 0;

  int exp_seq[$];
  bit exp_found;
  int exp_result;

  logic [2:0] bad_pats [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  sar_search_unit_if #(.WIDTH(WIDTH)) bus ();

  sar_search_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .result (result),
    .probes (probes),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cand"}, bus.cand, 0);
    chk({tag, "_cand_valid"}, bus.cand_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_probes"}, probes, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Binary search on plain integers; mode 1 is a responder that always answers lt.
  function automatic void model(input int mode, input int tgt);
    int lo;
    int hi;
    int mid;
    lo = 0;
    hi = MAXV;
    exp_seq.delete();
    exp_found  = 1'b0;
    exp_result = 0;
    for (int n = 0; n < WIDTH + 2; n++) begin
      mid = (lo + hi) / 2;
      exp_seq.push_back(mid);
      if (mode == 0 && mid == tgt) begin
        exp_found  = 1'b1;
        exp_result = mid;
        return;
      end
      if (mode == 0 && tgt > mid) lo = mid + 1;
      else hi = mid - 1;
      if (lo > hi) begin
        exp_result = mid;
        return;
      end
    end
  endfunction

  function automatic logic [2:0] cmp_pat(input int tgt, input int c);
    if (tgt > c)       return 3'b100;
    else if (tgt == c) return 3'b010;
    else               return 3'b001;
  endfunction

  task automatic drive_verdict(input logic [2:0] v);
    bus.x_gt_y = v[2];
    bus.x_eq_y = v[1];
    bus.x_lt_y = v[0];
  endtask

  // mode 0: consistent, 1: always lt, 2: malformed verdict at probe index bad_at_in.
  task automatic run_search(input int mode, input int tgt, input int bad_at_in,
                            input logic [2:0] bad_pat, input int stall_at,
                            input int stall_n, input bit poke, input bit noisy_start);
    int bad_at;
    int k;
    int i;
    int cyc;
    int stalls;
    bit seen;
    model(mode == 2 ? 0 : mode, tgt);
    bad_at = bad_at_in;
    if (bad_at >= exp_seq.size()) bad_at = exp_seq.size() - 1;
    if (mode == 2) begin
      while (exp_seq.size() > bad_at + 1) void'(exp_seq.pop_back());
      exp_found  = 1'b0;
      exp_result = exp_seq[bad_at];
    end
    k = exp_seq.size();

    @(negedge clk);
    start = 1'b1;
    bus.resp_valid = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    cyc    = 1;
    i      = 0;
    stalls = 0;
    seen   = 1'b0;
    while (cyc < 40) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("busy_during_search", busy, 1);
      if (i < k) begin
        chk("cand_valid", bus.cand_valid, 1);
        chk("cand", bus.cand, exp_seq[i]);
      end
      if (noisy_start) start = 1'($urandom_range(0, 1));
      if (i == stall_at && stalls < stall_n) begin
        bus.resp_valid = 1'b0;
        drive_verdict(3'($urandom));
        stalls++;
      end else begin
        bus.resp_valid = 1'b1;
        if (mode == 2 && i == bad_at) drive_verdict(bad_pat);
        else if (mode == 1)           drive_verdict(3'b001);
        else if (i < k)               drive_verdict(cmp_pat(tgt, exp_seq[i]));
        else                          drive_verdict(3'b010);
        i++;
      end
      @(negedge clk);
      cyc++;
    end

    chk("done_seen", seen, 1);
    if (seen) begin
      chk("latency", cyc, k + 1 + stalls);
      chk("done_busy", busy, 1);
      chk("done_cand_valid", bus.cand_valid, 0);
      chk("found", found, exp_found);
      chk("result", result, exp_result);
      chk("probes", probes, k);
      chk("err", err, mode == 2 ? 1 : 0);
      start = poke;
      bus.resp_valid = 1'($urandom);
      drive_verdict(3'($urandom));
      @(negedge clk);
      start = 1'b0;
      chk("idle_done_low", done, 0);
      chk("idle_busy_low", busy, 0);
      chk("idle_found_held", found, exp_found);
      @(negedge clk);
      chk("start_in_done_ignored", busy, 0);
      chk("idle_result_held", result, exp_result);
    end
    start = 1'b0;
    bus.resp_valid = 1'b0;
  endtask

  task automatic reset_mid_search();
    int i;
    model(0, 10);
    @(negedge clk);
    start = 1'b1;
    bus.resp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (i < 2) begin
      bus.resp_valid = 1'b1;
      drive_verdict(cmp_pat(10, exp_seq[i]));
      i++;
      @(negedge clk);
    end
    chk("rst_third_cand", bus.cand, 9);
    chk("rst_third_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid_async");
    bus.resp_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid_release");
  endtask

  initial begin
    int mode;
    rst_n = 1'b1;
    start = 1'b0;
    bus.resp_valid = 1'b0;
    drive_verdict(3'b000);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("reset_release");

    // Hand-computed sequences pinning the model.
    model(0, 0);
    chk("model_t0_len", exp_seq.size(), 4);
    chk("model_t0_p1", exp_seq[1], 3);
    chk("model_t0_p3", exp_seq[3], 0);
    model(0, 15);
    chk("model_t15_len", exp_seq.size(), 5);
    chk("model_t15_p2", exp_seq[2], 13);
    model(1, 5);
    chk("model_lt_found", exp_found, 0);
    chk("model_lt_len", exp_seq.size(), 4);

    run_search(0, 7, 0, 3'b000, 99, 0, 1'b0, 1'b0);
    chk("t7_found", found, 1);
    chk("t7_result", result, 7);
    chk("t7_probes", probes, 1);

    run_search(0, 15, 0, 3'b000, 99, 0, 1'b0, 1'b0);
    chk("t15_result", result, 15);
    chk("t15_probes", probes, 5);

    run_search(0, 0, 0, 3'b000, 99, 0, 1'b0, 1'b0);
    chk("t0_result", result, 0);
    chk("t0_probes", probes, 4);

    run_search(0, 10, 0, 3'b000, 99, 0, 1'b1, 1'b0);
    chk("t10_result", result, 10);
    chk("t10_probes", probes, 4);

    run_search(1, 9, 0, 3'b000, 99, 0, 1'b0, 1'b0);
    chk("always_lt_found", found, 0);
    chk("always_lt_err", err, 0);
    chk("always_lt_result", result, 0);
    chk("always_lt_probes", probes, 4);

    run_search(2, 12, 1, 3'b101, 1, 3, 1'b0, 1'b0);
    chk("malformed_err", err, 1);
    chk("malformed_found", found, 0);
    chk("malformed_result", result, 11);
    chk("malformed_probes", probes, 2);

    reset_mid_search();
    run_search(0, 7, 0, 3'b000, 99, 0, 1'b0, 1'b0);
    chk("post_rst_probes", probes, 1);
    chk("post_rst_result", result, 7);

    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 5);
      mode = (mode <= 3) ? 0 : mode - 3;
      run_search(mode, $urandom_range(0, MAXV), $urandom_range(0, 4),
                 bad_pats[$urandom_range(0, 4)], $urandom_range(0, 5),
                 $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
